// File: rtl/zmc2_dot_pipe_if.sv
// Character-ROM word handshake into the dot pipe: one planar word plus its
// per-word H-flip and lane rotation, offered with a valid/ready pair.
interface zmc2_dot_pipe_if #(
    parameter int BPP    = 4,
    parameter int PIXELS = 8,
    parameter int LANES  = 2
);
    logic [BPP*PIXELS-1:0]    CR;
    logic                     CR_H;
    logic [$clog2(LANES)-1:0] CR_OFS;
    logic                     CR_VALID;
    logic                     CR_READY;

    modport master (output CR, CR_H, CR_OFS, CR_VALID, input CR_READY);
    modport slave  (input CR, CR_H, CR_OFS, CR_VALID, output CR_READY);
endinterface

// File: rtl/zmc2_dot_pipe.sv
// Planar C-ROM word serialiser: one word of look-ahead buffering, LANES pixels
// per enabled falling CLK_12M edge, per-word H-flip and lane rotation, sticky underflow.
module zmc2_dot_pipe #(
    parameter int BPP    = 4,
    parameter int PIXELS = 8,
    parameter int LANES  = 2
) (
    input  logic                  CLK_12M,
    input  logic                  nRESET,
    input  logic                  FLUSH,
    zmc2_dot_pipe_if.slave        cr,
    input  logic                  EN,
    output logic [LANES*BPP-1:0]  GD,
    output logic [LANES-1:0]      DOT,
    output logic                  PIX_VALID,
    output logic                  UNDERFLOW
);
    localparam int STEPS = PIXELS / LANES;
    localparam int OW    = $clog2(LANES);
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IW    = $clog2(PIXELS);
    localparam int PW    = SW + OW;
    localparam int WW    = BPP * PIXELS;

    logic [WW-1:0] hold_word_q, hold_word_d;
    logic          hold_h_q, hold_h_d;
    logic [OW-1:0] hold_ofs_q, hold_ofs_d;
    logic          h_full_q, h_full_d;
    logic [WW-1:0] act_word_q, act_word_d;
    logic          act_h_q, act_h_d;
    logic [OW-1:0] act_ofs_q, act_ofs_d;
    logic          act_valid_q, act_valid_d;
    logic [SW-1:0] step_q, step_d;
    logic          started_q, started_d;
    logic          underflow_q, underflow_d;

    logic accept, last_step, refill;

    assign cr.CR_READY = ~h_full_q;
    assign accept      = cr.CR_VALID & ~h_full_q;
    assign last_step   = (step_q == SW'(STEPS - 1));
    assign refill      = ~act_valid_q | (EN & last_step);

    always_comb begin
        hold_word_d = hold_word_q;
        hold_h_d    = hold_h_q;
        hold_ofs_d  = hold_ofs_q;
        h_full_d    = h_full_q;
        act_word_d  = act_word_q;
        act_h_d     = act_h_q;
        act_ofs_d   = act_ofs_q;
        act_valid_d = act_valid_q;
        step_d      = step_q;
        started_d   = started_q;
        underflow_d = underflow_q;
        if (FLUSH) begin
            h_full_d    = 1'b0;
            act_valid_d = 1'b0;
            step_d      = '0;
            started_d   = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (refill) begin
                // Ready is ~h_full, so a full hold can never accept on the same edge.
                if (h_full_q) begin
                    act_word_d  = hold_word_q;
                    act_h_d     = hold_h_q;
                    act_ofs_d   = hold_ofs_q;
                    act_valid_d = 1'b1;
                    step_d      = '0;
                    h_full_d    = 1'b0;
                    started_d   = 1'b1;
                end else if (accept) begin
                    act_word_d  = cr.CR;
                    act_h_d     = cr.CR_H;
                    act_ofs_d   = cr.CR_OFS;
                    act_valid_d = 1'b1;
                    step_d      = '0;
                    started_d   = 1'b1;
                end else begin
                    act_valid_d = 1'b0;
                    step_d      = '0;
                end
            end else begin
                if (EN && act_valid_q)
                    step_d = step_q + 1'b1;
                if (accept) begin
                    hold_word_d = cr.CR;
                    hold_h_d    = cr.CR_H;
                    hold_ofs_d  = cr.CR_OFS;
                    h_full_d    = 1'b1;
                end
            end
            if (EN && started_q && !act_valid_d)
                underflow_d = 1'b1;
        end
    end

    always_ff @(negedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            hold_word_q <= '0;
            hold_h_q    <= 1'b0;
            hold_ofs_q  <= '0;
            h_full_q    <= 1'b0;
            act_word_q  <= '0;
            act_h_q     <= 1'b0;
            act_ofs_q   <= '0;
            act_valid_q <= 1'b0;
            step_q      <= '0;
            started_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            hold_word_q <= hold_word_d;
            hold_h_q    <= hold_h_d;
            hold_ofs_q  <= hold_ofs_d;
            h_full_q    <= h_full_d;
            act_word_q  <= act_word_d;
            act_h_q     <= act_h_d;
            act_ofs_q   <= act_ofs_d;
            act_valid_q <= act_valid_d;
            step_q      <= step_d;
            started_q   <= started_d;
            underflow_q <= underflow_d;
        end
    end

    logic [BPP-1:0][PIXELS-1:0] planes;
    assign planes = act_word_q;

    // Pixel index is {step, rotated lane}; H-flip mirrors it across the word.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [OW-1:0] j;
        logic [PW-1:0] k, p_full;
        logic [IW-1:0] p;
        assign j      = OW'(l) + act_ofs_q;
        assign k      = {step_q, j};
        assign p_full = act_h_q ? (PW'(PIXELS - 1) - k) : k;
        assign p      = IW'(p_full);
        for (genvar b = 0; b < BPP; b++) begin : g_bit
            assign GD[l*BPP+b] = act_valid_q & planes[b][p];
        end
        assign DOT[l] = |GD[l*BPP +: BPP];
    end

    assign PIX_VALID = act_valid_q;
    assign UNDERFLOW = underflow_q;
endmodule

// File: tb/tb_zmc2_dot_pipe.sv
// Directed bench for zmc2_dot_pipe: the driver queues hand-computed GD per step,
// and a posedge monitor checks every presented step and pops it once it is consumed.
module tb_zmc2_dot_pipe;
    localparam int BPP = 4, PIXELS = 8, LANES = 2;

    logic       CLK_12M = 1'b0;
    logic       nRESET  = 1'b0;
    logic       FLUSH   = 1'b0;
    logic       EN      = 1'b0;
    logic [7:0] GD;
    logic [1:0] DOT;
    logic       PIX_VALID, UNDERFLOW;

    zmc2_dot_pipe_if #(.BPP(BPP), .PIXELS(PIXELS), .LANES(LANES)) cr_if ();

    zmc2_dot_pipe #(.BPP(BPP), .PIXELS(PIXELS), .LANES(LANES)) dut (
        .CLK_12M   (CLK_12M),
        .nRESET    (nRESET),
        .FLUSH     (FLUSH),
        .cr        (cr_if),
        .EN        (EN),
        .GD        (GD),
        .DOT       (DOT),
        .PIX_VALID (PIX_VALID),
        .UNDERFLOW (UNDERFLOW)
    );

    always #5 CLK_12M = ~CLK_12M;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb[$];

    // pixel p of W has colour p
    localparam logic [31:0] W = 32'h00F0CCAA;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK_12M);
        #1;
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d);
    endtask

    task automatic offer(input logic [31:0] w, input logic h, input logic ofs);
        cr_if.CR       = w;
        cr_if.CR_H     = h;
        cr_if.CR_OFS   = ofs;
        cr_if.CR_VALID = 1'b1;
    endtask

    // Monitor: compare every presented step; pop only if EN consumes it on the next falling edge.
    initial begin
        logic       v;
        logic [7:0] g;
        logic [1:0] d;
        logic [7:0] e;
        forever begin
            @(posedge CLK_12M);
            v = PIX_VALID; g = GD; d = DOT;
            if (v) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pixel: got GD %0h with nothing expected at %0t", g, $time);
                end else begin
                    e = sb[0];
                    check("gd", {24'd0, g}, {24'd0, e});
                    check("dot", {30'd0, d}, {30'd0, |e[7:4], |e[3:0]});
                end
                #2;
                if (EN && sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        cr_if.CR = '0; cr_if.CR_H = 1'b0; cr_if.CR_OFS = 1'b0; cr_if.CR_VALID = 1'b0;
        tick(); tick();
        nRESET = 1'b1;
        EN     = 1'b1;
        tick();
        check("rst_ready", cr_if.CR_READY, 1);
        check("rst_pix_valid", PIX_VALID, 0);
        check("rst_gd", GD, 0);
        check("rst_dot", DOT, 0);
        check("rst_underflow", UNDERFLOW, 0);

        // single word, then starvation -> underflow; flush clears it
        offer(W, 1'b0, 1'b0);
        push4(8'h10, 8'h32, 8'h54, 8'h76);
        tick();
        cr_if.CR_VALID = 1'b0;
        repeat (4) tick();
        check("t1_pix_valid_end", PIX_VALID, 0);
        check("t1_underflow", UNDERFLOW, 1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("t1_flush_underflow", UNDERFLOW, 0);
        check("t1_flush_ready", cr_if.CR_READY, 1);

        // back-to-back: H-flip word bypasses, rotated word waits in hold
        offer(W, 1'b1, 1'b0);
        push4(8'h67, 8'h45, 8'h23, 8'h01);
        tick();
        offer(W, 1'b0, 1'b1);
        push4(8'h01, 8'h23, 8'h45, 8'h67);
        tick();
        cr_if.CR_VALID = 1'b0;
        check("t2_ready_full1", cr_if.CR_READY, 0);
        tick();
        check("t2_ready_full2", cr_if.CR_READY, 0);
        tick();
        check("t2_ready_full3", cr_if.CR_READY, 0);
        check("t2_valid_last", PIX_VALID, 1);
        tick();
        check("t2_ready_reopen", cr_if.CR_READY, 1);
        check("t2_no_gap", PIX_VALID, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_valid_w2", PIX_VALID, 1);
        end
        tick();
        check("t2_pix_valid_end", PIX_VALID, 0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;

        // EN held low for 5 edges at step 2
        offer(W, 1'b0, 1'b0);
        push4(8'h10, 8'h32, 8'h54, 8'h76);
        tick();
        cr_if.CR_VALID = 1'b0;
        tick(); tick();
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_frozen_gd", GD, 8'h54);
        end
        check("t3_frozen_no_underflow", UNDERFLOW, 0);
        EN = 1'b1;
        tick();
        check("t3_resume_gd", GD, 8'h76);
        tick();
        check("t3_underflow", UNDERFLOW, 1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;

        // async reset at step 2
        offer(W, 1'b0, 1'b0);
        push4(8'h10, 8'h32, 8'h54, 8'h76);
        tick();
        cr_if.CR_VALID = 1'b0;
        tick(); tick();
        nRESET = 1'b0;
        #1;
        check("t4_rst_pix_valid", PIX_VALID, 0);
        check("t4_rst_gd", GD, 0);
        check("t4_rst_dot", DOT, 0);
        check("t4_rst_ready", cr_if.CR_READY, 1);
        #1;
        sb.delete();
        tick();
        nRESET = 1'b1;
        tick();
        check("t4_after_release", PIX_VALID, 0);
        tick();
        check("t4_after_release2", PIX_VALID, 0);

        // FLUSH beats a same-edge accept
        FLUSH = 1'b1;
        offer(W, 1'b0, 1'b0);
        tick();
        FLUSH = 1'b0;
        cr_if.CR_VALID = 1'b0;
        check("t5_dropped", PIX_VALID, 0);
        check("t5_ready", cr_if.CR_READY, 1);
        tick();
        check("t5_still_empty", PIX_VALID, 0);
        check("t5_no_underflow", UNDERFLOW, 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
